// File: rtl/apb_event_completer.sv
// APB completer that pushes write data into an event FIFO drained by a valid/ready consumer.
// Blocked pushes insert wait states and are dropped with an error after TIMEOUT cycles.
module apb_event_completer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        evt_valid,
  output logic [31:0] evt_data,
  input  logic        evt_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WaitLast  = WW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [WW-1:0] wait_q;
  logic [7:0]    drop_q;
  logic [15:0]   count_q;

  logic        access, sel_push, sel_stat, sel_cnt;
  logic        full, empty, pop, push_req, push_ok, push_drop, cnt_clr;
  logic [5:0]  reg_idx;
  logic [31:0] status;

  assign access    = psel & penable & ~reset;
  assign reg_idx   = paddr[7:2];
  assign sel_push  = (reg_idx == 6'd0);
  assign sel_stat  = (reg_idx == 6'd1);
  assign sel_cnt   = (reg_idx == 6'd2);

  assign full      = (level_q == LevelFull);
  assign empty     = (level_q == '0);
  assign evt_valid = ~empty & ~reset;
  assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign pop       = evt_valid & evt_ready;

  // A full FIFO still accepts when the consumer frees a slot in the same cycle.
  assign push_req  = access & pwrite & sel_push;
  assign push_ok   = push_req & (~full | pop);
  assign push_drop = push_req & ~push_ok & (wait_q == WaitLast);
  assign cnt_clr   = access & pwrite & sel_cnt;

  assign status    = {16'h0, drop_q, 2'b00, empty, full, 4'(level_q)};

  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h0;
    if (access) begin
      if (sel_push) begin
        if (!pwrite || push_ok) begin
          pready = 1'b1;
        end else if (push_drop) begin
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end else if (sel_stat) begin
        pready = 1'b1;
        if (pwrite) pslverr = 1'b1;
        else        prdata  = status;
      end else if (sel_cnt) begin
        pready = 1'b1;
        if (!pwrite) prdata = {16'h0, count_q};
      end else begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      wait_q   <= '0;
      drop_q   <= 8'h0;
      count_q  <= 16'h0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= pwdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);

      if (push_ok && !pop)      level_q <= level_q + LW'(1);
      else if (!push_ok && pop) level_q <= level_q - LW'(1);

      if (push_drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;

      if (cnt_clr)  count_q <= pop ? 16'd1 : 16'd0;
      else if (pop) count_q <= count_q + 16'd1;

      if (!psel || pready) wait_q <= '0;
      else if (push_req)   wait_q <= wait_q + WW'(1);
    end
  end

endmodule

// File: tb/tb_apb_event_completer.sv
// Randomized bench for apb_event_completer: a queue-based event model predicts every cycle's
// outputs into a scoreboard that a negedge monitor drains and compares.
module tb_apb_event_completer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset, psel, penable, pwrite, evt_ready;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata, evt_data;
  logic        pready, pslverr, evt_valid;

  apb_event_completer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        err;
    logic [31:0] rd;
    logic        v;
    logic [31:0] d;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          wcnt = 0;
  int          drop = 0;
  logic [15:0] cnt  = 16'h0;
  logic        last_rdy;
  int          ready_mode = 0;
  int          ready_at   = -1;

  task automatic step();
    exp_t        e;
    logic        pop, acc, push_ok, clr;
    int          idx;
    logic [31:0] st;
    e = '{rdy: 1'b0, err: 1'b0, rd: 32'h0, v: 1'b0, d: 32'h0};
    if (reset) begin
      mq.delete();
      wcnt = 0;
      drop = 0;
      cnt  = 16'h0;
    end else begin
      e.v     = (mq.size() > 0);
      e.d     = e.v ? mq[0] : 32'h0;
      pop     = e.v && evt_ready;
      acc     = psel && penable;
      idx     = int'(paddr[7:2]);
      push_ok = 1'b0;
      clr     = 1'b0;
      st      = {16'h0, 8'(drop), 2'b00, mq.size() == 0, mq.size() == DEPTH, 4'(mq.size())};
      if (acc) begin
        if (idx == 0) begin
          if (!pwrite) e.rdy = 1'b1;
          else if (mq.size() < DEPTH || pop) begin
            e.rdy   = 1'b1;
            push_ok = 1'b1;
          end else if (wcnt == TIMEOUT - 1) begin
            e.rdy = 1'b1;
            e.err = 1'b1;
            if (drop < 255) drop++;
          end
        end else if (idx == 1) begin
          e.rdy = 1'b1;
          if (pwrite) e.err = 1'b1;
          else        e.rd  = st;
        end else if (idx == 2) begin
          e.rdy = 1'b1;
          if (pwrite) clr = 1'b1;
          else        e.rd = {16'h0, cnt};
        end else begin
          e.rdy = 1'b1;
          e.err = 1'b1;
        end
      end
      if (pop) begin
        void'(mq.pop_front());
        cnt = cnt + 16'd1;
      end
      if (clr) cnt = pop ? 16'd1 : 16'd0;
      if (push_ok) mq.push_back(pwdata);
      if (!psel || e.rdy) wcnt = 0;
      else if (acc && pwrite && idx == 0) wcnt++;
    end
    expq.push_back(e);
    last_rdy = e.rdy;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      tests++;
      if ({pready, pslverr, prdata, evt_valid, evt_data} !== {e.rdy, e.err, e.rd, e.v, e.d}) begin
        fails++;
        $display("FAIL cycle %0d: got pready=%b pslverr=%b prdata=%h evt_valid=%b evt_data=%h, want %b %b %h %b %h",
                 cyc, pready, pslverr, prdata, evt_valid, evt_data, e.rdy, e.err, e.rd, e.v, e.d);
      end
    end
  end

  task automatic set_ready(input int k);
    case (ready_mode)
      0:       evt_ready = 1'b0;
      1:       evt_ready = 1'b1;
      default: evt_ready = ($urandom_range(0, 3) == 0);
    endcase
    if (k >= 0 && k == ready_at) evt_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      psel    = 1'b0;
      penable = 1'b0;
      set_ready(-1);
      step();
    end
  endtask

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                     input int rst_at, input logic abort);
    int   k;
    logic done;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    set_ready(-1);
    step();
    penable = 1'b1;
    k       = 0;
    done    = 1'b0;
    while (!done) begin
      set_ready(k);
      if (rst_at >= 0 && k == rst_at) begin
        reset = 1'b1;
        if (abort) begin
          psel    = 1'b0;
          penable = 1'b0;
        end
        step();
        step();
        reset = 1'b0;
        if (abort) done = 1'b1;
      end else begin
        step();
        done = last_rdy;
      end
      k++;
      if (k > 200) begin
        $display("FAIL bound: transfer at addr %h never completed", addr);
        $fatal(1, "transfer bound expired");
      end
    end
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  initial begin
    logic [7:0]  a;
    logic        w;
    int          r, ra;
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h0; pwdata = 32'h0; evt_ready = 1'b0;
    @(posedge clk);
    #1;
    idle(3);
    reset = 1'b0;
    idle(2);

    // Single push observed by an always-ready consumer, then EVT_COUNT
    ready_mode = 1;
    apb(1'b1, 8'h00, 32'hA5A5_0001, -1, 1'b0);
    idle(2);
    apb(1'b0, 8'h08, 32'h0, -1, 1'b0);

    // Fill, status, timed-out push
    ready_mode = 0;
    for (int i = 0; i < 4; i++) apb(1'b1, 8'h00, 32'h1000_0000 + i, -1, 1'b0);
    apb(1'b0, 8'h04, 32'h0, -1, 1'b0);
    apb(1'b1, 8'h00, 32'hDEAD_0005, -1, 1'b0);
    apb(1'b0, 8'h04, 32'h0, -1, 1'b0);

    // Blocked push released by a pop on wait cycle 3
    ready_at = 3;
    apb(1'b1, 8'h00, 32'h2000_0006, -1, 1'b0);
    ready_at = -1;
    apb(1'b0, 8'h04, 32'h0, -1, 1'b0);
    ready_mode = 1;
    idle(6);

    // Decode errors
    apb(1'b0, 8'h10, 32'h0, -1, 1'b0);
    apb(1'b1, 8'h04, 32'hFFFF_FFFF, -1, 1'b0);
    apb(1'b0, 8'h04, 32'h0, -1, 1'b0);

    // EVT_COUNT clear coinciding with a pop
    ready_mode = 0;
    apb(1'b1, 8'h00, 32'h3000_0001, -1, 1'b0);
    apb(1'b1, 8'h00, 32'h3000_0002, -1, 1'b0);
    ready_mode = 1;
    apb(1'b1, 8'h08, 32'h1234_5678, -1, 1'b0);
    apb(1'b0, 8'h08, 32'h0, -1, 1'b0);

    // Reset mid-stall: abandoned transfer, then one kept active across release
    ready_mode = 0;
    for (int i = 0; i < 4; i++) apb(1'b1, 8'h00, 32'h4000_0000 + i, -1, 1'b0);
    apb(1'b1, 8'h00, 32'h4000_0004, 5, 1'b1);
    apb(1'b0, 8'h04, 32'h0, -1, 1'b0);
    for (int i = 0; i < 4; i++) apb(1'b1, 8'h00, 32'h5000_0000 + i, -1, 1'b0);
    apb(1'b1, 8'h00, 32'h5000_0004, 2, 1'b0);
    apb(1'b0, 8'h04, 32'h0, -1, 1'b0);

    // Drop counter saturation
    for (int i = 0; i < 3; i++) apb(1'b1, 8'h00, 32'h6000_0000 + i, -1, 1'b0);
    for (int i = 0; i < 258; i++) apb(1'b1, 8'h00, 32'h7000_0000 + i, -1, 1'b0);
    apb(1'b0, 8'h04, 32'h0, -1, 1'b0);
    ready_mode = 1;
    idle(6);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      if (t % 25 == 0) ready_mode = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r < 5)       a = 8'h00;
      else if (r == 5) a = 8'h04;
      else if (r == 6) a = 8'h08;
      else if (r == 7) a = 8'h0C;
      else             a = 8'($urandom_range(0, 255));
      a  = {a[7:2], 2'($urandom_range(0, 3))};
      w  = (r < 5) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 49) == 0) ? $urandom_range(0, 20) : -1;
      apb(w, a, $urandom, ra, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
